// File: rtl/seg_scan_driver.sv
// seg_scan_driver: time-multiplexed driver for a two-digit seven-segment display.
//
// Each frame is SHOW_ONES, DEAD_1, SHOW_TENS, DEAD_0. Show states last SCAN_DIV
// cycles and dead states last DEAD_CYCLES cycles. The segment inputs and
// blink_en are sampled only at frame start, so a frame can never tear.
// All outputs come from flops.
//
// Ports:
//   clk              rising-edge clock
//   rst_n            synchronous active-low reset
//   display_segments [13:7] tens code, [6:0] ones code (passed through as-is)
//   blink_en         blink the whole display every BLINK_FRAMES frames
//   seg              segment drive for the digit that is currently lit
//   dig_n            active-low digit enables: [0] ones, [1] tens
//   frame_done       one-cycle pulse in the first cycle of each SHOW_ONES
module seg_scan_driver #(
    parameter int SCAN_DIV     = 50000,
    parameter int DEAD_CYCLES  = 16,
    parameter int BLINK_FRAMES = 250
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [13:0] display_segments,
    input  logic        blink_en,
    output logic [6:0]  seg,
    output logic [1:0]  dig_n,
    output logic        frame_done
);

    localparam int CNT_MAX = (SCAN_DIV > DEAD_CYCLES) ? SCAN_DIV : DEAD_CYCLES;
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int FW      = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] DEAD_LAST = CW'(DEAD_CYCLES - 1);
    localparam logic [FW-1:0] FRM_LAST  = FW'(BLINK_FRAMES - 1);

    typedef enum logic [1:0] {
        SHOW_ONES,
        DEAD_1,
        SHOW_TENS,
        DEAD_0
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [FW-1:0] frm_q, frm_d;
    logic          blink_off_q, blink_off_d;
    logic          blank_q, blank_d;
    logic [13:0]   snap_q, snap_d;
    logic [6:0]    seg_q, seg_d;
    logic [1:0]    dig_n_q, dig_n_d;
    logic          frame_done_q, frame_done_d;

    logic          phase_last;
    logic          frame_start;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q + 1'b1;
        frm_d        = frm_q;
        blink_off_d  = blink_off_q;
        blank_d      = blank_q;
        snap_d       = snap_q;
        frame_start  = 1'b0;

        if (state_q == SHOW_ONES || state_q == SHOW_TENS)
            phase_last = (cnt_q == SCAN_LAST);
        else
            phase_last = (cnt_q == DEAD_LAST);

        if (phase_last) begin
            cnt_d = '0;
            case (state_q)
                SHOW_ONES: state_d = DEAD_1;
                DEAD_1:    state_d = SHOW_TENS;
                SHOW_TENS: state_d = DEAD_0;
                default: begin
                    state_d     = SHOW_ONES;
                    frame_start = 1'b1;
                end
            endcase
        end

        // blink_off is updated at frame start, but the frame being started is
        // blanked by the value held before that update. This puts the toggle
        // after BLINK_FRAMES counted frames. It also means that when blink is
        // first enabled, BLINK_FRAMES lit frames come before the first dark one.
        if (frame_start) begin
            snap_d  = display_segments;
            blank_d = blink_en & blink_off_q;
            if (blink_en) begin
                if (frm_q == FRM_LAST) begin
                    frm_d       = '0;
                    blink_off_d = ~blink_off_q;
                end else begin
                    frm_d = frm_q + 1'b1;
                end
            end else begin
                frm_d       = '0;
                blink_off_d = 1'b0;
            end
        end

        // Outputs are computed from the next state and registered, so they
        // line up with state_q.
        seg_d        = 7'b0;
        dig_n_d      = 2'b11;
        frame_done_d = frame_start;
        case (state_d)
            SHOW_ONES: begin
                seg_d   = snap_d[6:0];
                dig_n_d = blank_d ? 2'b11 : 2'b10;
            end
            SHOW_TENS: begin
                seg_d   = snap_d[13:7];
                dig_n_d = blank_d ? 2'b11 : 2'b01;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= DEAD_0;
            cnt_q        <= '0;
            frm_q        <= '0;
            blink_off_q  <= 1'b0;
            blank_q      <= 1'b0;
            snap_q       <= 14'b0;
            seg_q        <= 7'b0;
            dig_n_q      <= 2'b11;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            frm_q        <= frm_d;
            blink_off_q  <= blink_off_d;
            blank_q      <= blank_d;
            snap_q       <= snap_d;
            seg_q        <= seg_d;
            dig_n_q      <= dig_n_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign seg        = seg_q;
    assign dig_n      = dig_n_q;
    assign frame_done = frame_done_q;

endmodule
